// File: rtl/switch_debounce_if.sv
// Switch debouncer bus: raw switch levels in, debounced levels and edge pulses out.
interface switch_debounce_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             stable;

  modport master (output sw_in, input sw_out, sw_rise, sw_fall, stable);
  modport slave  (input sw_in, output sw_out, sw_rise, sw_fall, stable);
endinterface

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer: per-channel 2-flop sync, qualify counter and
// edge pulses, plus a global "nothing pending" flag.
module switch_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall,
  output logic idle
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic             sync1, sync2;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             diff;

  assign diff = sync2 ^ sw_out;
  assign idle = (state == IDLE) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sw_out  <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
    end else begin
      sync1   <= sw_in;
      sync2   <= sync1;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      case (state)
        IDLE: begin
          // IDLE always holds cnt==0 and LAST>=1, so no toggle can happen here
          if (diff) begin
            state <= COUNT;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (!diff) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            sw_out  <= ~sw_out;
            sw_rise <= ~sw_out;
            sw_fall <= sw_out;
            state   <= IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end
endmodule

module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WIDTH           = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_debounce_if.slave     bus
);
  logic [WIDTH-1:0] sw_in_w, sw_out_w, sw_rise_w, sw_fall_w, idle_w;
  logic             stable_q;

  assign sw_in_w = bus.sw_in;

  switch_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [WIDTH-1:0] (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in_w),
    .sw_out  (sw_out_w),
    .sw_rise (sw_rise_w),
    .sw_fall (sw_fall_w),
    .idle    (idle_w)
  );

  always_ff @(posedge clk) begin
    if (rst) stable_q <= 1'b0;
    else     stable_q <= &idle_w;
  end

  assign bus.sw_out  = sw_out_w;
  assign bus.sw_rise = sw_rise_w;
  assign bus.sw_fall = sw_fall_w;
  assign bus.stable  = stable_q;
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4 (output latency 6 edges).
module tb_switch_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  switch_debounce_if #(.WIDTH(5)) bus ();

  switch_debounce #(.DEBOUNCE_CYCLES(4), .WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one rising edge, then check {sw_out, sw_rise, sw_fall}
  task automatic cyc(input string tag, input logic [4:0] eo, input logic [4:0] er,
                     input logic [4:0] ef);
    @(posedge clk); #1;
    chk(tag, {1'b0, bus.sw_out, bus.sw_rise, bus.sw_fall}, {1'b0, eo, er, ef});
  endtask

  task automatic chk_stable(input string tag, input logic exp);
    chk(tag, {15'd0, bus.stable}, {15'd0, exp});
  endtask

  // downstream AOI: F = ~((A&B&C) | (D&E)), {A,B,C,D,E} = sw_out[4:0]
  function automatic logic aoi(input logic [4:0] v);
    return ~((v[4] & v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  initial begin
    int bounce [6] = '{1, 0, 1, 1, 0, 1};
    bus.sw_in = 5'b00000;

    // reset state
    rst = 1'b1;
    cyc("reset_outputs", 5'b00000, 5'b00000, 5'b00000);
    cyc("reset_outputs2", 5'b00000, 5'b00000, 5'b00000);
    chk_stable("reset_stable", 1'b0);
    rst = 1'b0;
    cyc("post_rst1", 5'b00000, 5'b00000, 5'b00000);
    cyc("post_rst2", 5'b00000, 5'b00000, 5'b00000);
    chk_stable("post_rst_stable", 1'b1);

    // clean step on channel 0: out at edge 6, one rise pulse
    bus.sw_in = 5'b00001;
    cyc("step_e1", 5'b00000, 5'b00000, 5'b00000);
    cyc("step_e2", 5'b00000, 5'b00000, 5'b00000);
    chk_stable("step_stable_e2", 1'b1);
    cyc("step_e3", 5'b00000, 5'b00000, 5'b00000);
    cyc("step_e4", 5'b00000, 5'b00000, 5'b00000);
    chk_stable("step_stable_e4", 1'b0);
    cyc("step_e5", 5'b00000, 5'b00000, 5'b00000);
    cyc("step_e6", 5'b00001, 5'b00001, 5'b00000);
    chk_stable("step_stable_e6", 1'b0);
    cyc("step_e7", 5'b00001, 5'b00000, 5'b00000);
    chk_stable("step_stable_e7", 1'b1);

    // 3-cycle glitch on channel 2 must be filtered
    bus.sw_in = 5'b00101;
    repeat (3) cyc("glitch_hi", 5'b00001, 5'b00000, 5'b00000);
    bus.sw_in = 5'b00001;
    repeat (8) cyc("glitch_lo", 5'b00001, 5'b00000, 5'b00000);
    chk_stable("glitch_stable", 1'b1);

    // bounce on channel 4, rise 6 edges after the final 0->1 sample
    for (int i = 0; i < 5; i++) begin
      bus.sw_in = {bounce[i][0], 4'b0001};
      cyc("bounce", 5'b00001, 5'b00000, 5'b00000);
    end
    bus.sw_in = {bounce[5][0], 4'b0001};
    repeat (5) cyc("bounce_hold", 5'b00001, 5'b00000, 5'b00000);
    cyc("bounce_rise", 5'b10001, 5'b10000, 5'b00000);
    repeat (3) cyc("bounce_after", 5'b10001, 5'b00000, 5'b00000);

    // return to zero, then multi-channel changes
    bus.sw_in = 5'b00000;
    repeat (5) cyc("clr_wait", 5'b10001, 5'b00000, 5'b00000);
    cyc("clr_fall", 5'b00000, 5'b00000, 5'b10001);
    bus.sw_in = 5'b11100;
    repeat (5) cyc("multi1_wait", 5'b00000, 5'b00000, 5'b00000);
    cyc("multi1_edge", 5'b11100, 5'b11100, 5'b00000);
    cyc("multi1_after", 5'b11100, 5'b00000, 5'b00000);
    bus.sw_in = 5'b00011;
    repeat (5) cyc("multi2_wait", 5'b11100, 5'b00000, 5'b00000);
    cyc("multi2_edge", 5'b00011, 5'b00011, 5'b11100);
    cyc("multi2_after", 5'b00011, 5'b00000, 5'b00000);

    // reset mid-count on channel 1 discards it; requalified after release
    bus.sw_in = 5'b00000;
    repeat (5) cyc("pre_rst_wait", 5'b00011, 5'b00000, 5'b00000);
    cyc("pre_rst_fall", 5'b00000, 5'b00000, 5'b00011);
    repeat (2) cyc("pre_rst_idle", 5'b00000, 5'b00000, 5'b00000);
    bus.sw_in = 5'b00010;
    repeat (4) cyc("count_before_rst", 5'b00000, 5'b00000, 5'b00000);
    rst = 1'b1;
    cyc("mid_rst1", 5'b00000, 5'b00000, 5'b00000);
    chk_stable("mid_rst_stable", 1'b0);
    cyc("mid_rst2", 5'b00000, 5'b00000, 5'b00000);
    rst = 1'b0;
    repeat (5) cyc("requal_wait", 5'b00000, 5'b00000, 5'b00000);
    cyc("requal_rise", 5'b00010, 5'b00010, 5'b00000);
    cyc("requal_after", 5'b00010, 5'b00000, 5'b00000);

    // AOI stage: F stays 1 until A=B=C=1 has debounced
    bus.sw_in = 5'b11100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("aoi_before", {15'd0, aoi(bus.sw_out)}, 16'd1);
    end
    @(posedge clk); #1;
    chk("aoi_after", {15'd0, aoi(bus.sw_out)}, 16'd0);
    chk("aoi_out", {11'd0, bus.sw_out}, {11'd0, 5'b11100});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive clock cycles a changed input must hold (20 ms at 50 MHz); legal range 2 to 2^24.
REQ-002 Parameter WIDTH, default 5, SHALL set the number of independent switch channels; bit order {A,B,C,D,E} = [4:0] when driving the five-input AOI stage.
REQ-003 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sw_in  input  WIDTH  raw, asynchronous, bouncing board switches.
REQ-006 sw_out  output  WIDTH  debounced switch levels, fed directly to the downstream AOI gate inputs.
REQ-007 sw_rise  output  WIDTH  one-cycle pulse per channel when sw_out[i] goes 0->1.
REQ-008 sw_fall  output  WIDTH  one-cycle pulse per channel when sw_out[i] goes 1->0.
REQ-009 stable  output  1  high when no channel has a pending (counting) change.

Function
REQ-010 Each sw_in bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Each channel SHALL have a counter of width clog2(DEBOUNCE_CYCLES) and a 2-state FSM: IDLE (sync2 == sw_out) and COUNT (sync2 != sw_out).
REQ-012 IDLE -> COUNT when sync2[i] != sw_out[i]; counter SHALL increment by 1 each cycle the mismatch persists.
REQ-013 COUNT -> IDLE with counter cleared to 0, sw_out unchanged, on any cycle sync2[i] == sw_out[i] (bounce or glitch restarts qualification).
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, sw_out[i] SHALL toggle on that edge, the counter SHALL clear to 0 and the FSM SHALL return to IDLE.
REQ-015 Latency: a clean sw_in step held indefinitely SHALL appear on sw_out exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-016 Any level held fewer than DEBOUNCE_CYCLES consecutive cycles at sync2 SHALL never reach sw_out.
REQ-017 sw_rise[i]/sw_fall[i] SHALL be registered, asserted for exactly one cycle, in the same cycle sw_out[i] shows its new value; never both high on one channel.
REQ-018 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each complete on their own schedule, with no interaction.
REQ-019 stable SHALL be registered and equal 1 in the cycle after every channel is in IDLE with counter 0, else 0.
REQ-020 Counters SHALL never wrap; the toggle in REQ-014 is the only exit from the terminal count.
REQ-021 No combinational path SHALL exist from sw_in to any output.

Reset
REQ-022 While rst=1 at a rising edge: sync1, sync2, sw_out, sw_rise, sw_fall, stable, all counters SHALL become 0 and all FSMs IDLE.
REQ-023 Reset asserted mid-count SHALL discard the pending change; no pulse SHALL be emitted for it.
REQ-024 A switch held high through reset SHALL be requalified from scratch after release: sw_out=1 at DEBOUNCE_CYCLES+2 edges after release, with a sw_rise pulse.
REQ-025 stable SHALL read 0 during reset and 1 from the second edge after release if all sw_in are 0.

Verification (DEBOUNCE_CYCLES=4 override)
REQ-026 Reset then sw_in=5'b00001 held -> sw_out=5'b00001 exactly 6 edges later, sw_rise=5'b00001 for one cycle, stable 0 during count then 1.
REQ-027 sw_in[2] pulses high for 3 cycles then low -> sw_out stays 5'b00000, no sw_rise/sw_fall, stable returns to 1.
REQ-028 sw_in[4] bounces 1,0,1,1,0,1 then holds 1 -> sw_out[4] rises 6 edges after the final 0->1 sample, exactly one sw_rise[4].
REQ-029 sw_in=5'b11100 applied together, later 5'b00011 -> sw_out follows with latency 6, matching rise/fall pulse masks 5'b11100 then rise 5'b00011, fall 5'b11100.
REQ-030 rst asserted 2 cycles into a count on sw_in[1]=1 -> all outputs 0, no pulse; after release sw_out[1]=1 at 6 edges, one sw_rise[1].
REQ-031 Drive sw_out into the AOI stage with A=B=C=1, D=E=0 -> downstream F=0 only after debounce completes, F=1 before.
